// File: rtl/layer_compositor.sv
// layer_compositor
//   N-layer video compositor. Delays the VTG timing by SYNC_DLY stages so it
//   lines up with the sprite pixel pipeline, picks the highest-index enabled
//   requesting layer (or BG_COLOR, or black during blanking), and reports
//   per-frame layer overlap plus a frame counter at the start of vsync.
//
// Ports
//   i_clk, i_rst        pixel clock, synchronous active-high reset
//   i_hsync/i_vsync/i_blank/i_screen
//                       undelayed VTG timing; screen x=[9:0], y=[19:10]
//   i_vport             per-layer rgb, layer k at [k*24 +: 24]
//   i_req               per-layer opaque flag, aligned with i_vport
//   i_layer_en          layer enable mask, applied every cycle
//   o_hsync/o_vsync/o_screen
//                       delayed timing, aligned with o_vport
//   o_vport             composited {r,g,b}
//   o_collide           overlap flags of the previous frame
//   o_collide_stb       one-cycle pulse when o_collide updates
//   o_frame             frame counter, wraps at 8 bits
module layer_compositor #(
    parameter int          N_LAYERS = 4,
    parameter int          SYNC_DLY = 2,
    parameter logic        H_POL    = 1'b0,
    parameter logic        V_POL    = 1'b0,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_hsync,
    input  logic                     i_vsync,
    input  logic                     i_blank,
    input  logic [19:0]              i_screen,
    input  logic [N_LAYERS*24-1:0]   i_vport,
    input  logic [N_LAYERS-1:0]      i_req,
    input  logic [N_LAYERS-1:0]      i_layer_en,
    output logic                     o_hsync,
    output logic                     o_vsync,
    output logic [19:0]              o_screen,
    output logic [23:0]              o_vport,
    output logic [N_LAYERS-1:0]      o_collide,
    output logic                     o_collide_stb,
    output logic [7:0]               o_frame
);

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank;
        logic [19:0] screen;
    } tmg_t;

    // Idle timing: syncs inactive, blanked, origin. Keeps o_vport black while
    // the delay line refills after reset.
    localparam tmg_t TMG_RST = '{hs: ~H_POL, vs: ~V_POL, blank: 1'b1, screen: 20'd0};
    localparam logic [N_LAYERS-1:0] ONE = N_LAYERS'(1);

    tmg_t tmg_in;
    tmg_t tmg_d;

    assign tmg_in = '{hs: i_hsync, vs: i_vsync, blank: i_blank, screen: i_screen};

    // ------------------------------------------------------------------
    // Timing delay line
    // ------------------------------------------------------------------
    generate
        if (SYNC_DLY > 0) begin : g_dly
            tmg_t stg [SYNC_DLY];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < SYNC_DLY; i++) stg[i] <= TMG_RST;
                end else begin
                    stg[0] <= tmg_in;
                    for (int i = 1; i < SYNC_DLY; i++) stg[i] <= stg[i-1];
                end
            end

            assign tmg_d = stg[SYNC_DLY-1];
        end else begin : g_nodly
            assign tmg_d = tmg_in;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Layer selection and overlap detection
    // ------------------------------------------------------------------
    logic [N_LAYERS-1:0] eff;
    logic [23:0]         win_color;
    logic                multi;
    logic [N_LAYERS-1:0] acc;
    logic [N_LAYERS-1:0] acc_nxt;
    logic                vs_q;
    logic                frame_evt;

    assign eff = i_req & i_layer_en;

    // Ascending scan: the last (highest-index) hit overrides lower layers.
    always_comb begin
        win_color = BG_COLOR;
        for (int k = 0; k < N_LAYERS; k++) begin
            if (eff[k]) win_color = i_vport[k*24 +: 24];
        end
    end

    // Two or more bits set <=> clearing the lowest set bit leaves something.
    assign multi = |(eff & (eff - ONE));

    assign acc_nxt = (!tmg_d.blank && multi) ? (acc | eff) : acc;

    // Frame starts on the inactive->active edge of the delayed vsync.
    assign frame_evt = (tmg_d.vs == V_POL) && (vs_q != V_POL);

    // ------------------------------------------------------------------
    // Compositing stage
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hsync       <= ~H_POL;
            o_vsync       <= ~V_POL;
            o_screen      <= 20'd0;
            o_vport       <= 24'h000000;
            o_collide     <= '0;
            o_collide_stb <= 1'b0;
            o_frame       <= 8'd0;
            acc           <= '0;
            vs_q          <= ~V_POL;
        end else begin
            o_hsync       <= tmg_d.hs;
            o_vsync       <= tmg_d.vs;
            o_screen      <= tmg_d.screen;
            o_vport       <= tmg_d.blank ? 24'h000000 : win_color;
            vs_q          <= tmg_d.vs;
            o_collide_stb <= frame_evt;
            if (frame_evt) begin
                o_collide <= acc_nxt;
                acc       <= '0;
                o_frame   <= o_frame + 8'd1;
            end else begin
                acc       <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
module tb_layer_compositor;

    localparam int          N  = 4;
    localparam int          D  = 2;
    localparam logic [23:0] BG = 24'h203040;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_hsync, i_vsync, i_blank;
    logic [19:0]       i_screen;
    logic [N*24-1:0]   i_vport;
    logic [N-1:0]      i_req, i_layer_en;
    logic              o_hsync, o_vsync;
    logic [19:0]       o_screen;
    logic [23:0]       o_vport;
    logic [N-1:0]      o_collide;
    logic              o_collide_stb;
    logic [7:0]        o_frame;

    always #5 i_clk = ~i_clk;

    layer_compositor #(
        .N_LAYERS(N), .SYNC_DLY(D), .H_POL(1'b0), .V_POL(1'b0), .BG_COLOR(BG)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_hsync(i_hsync), .i_vsync(i_vsync), .i_blank(i_blank), .i_screen(i_screen),
        .i_vport(i_vport), .i_req(i_req), .i_layer_en(i_layer_en),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_screen(o_screen), .o_vport(o_vport),
        .o_collide(o_collide), .o_collide_stb(o_collide_stb), .o_frame(o_frame)
    );

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    // History of sampled timing inputs, indexed by edge number mod 8.
    // Edges before time zero count as reset edges.
    int          edge_n = 8;
    logic        h_rst [8];
    logic        h_hs  [8];
    logic        h_vs  [8];
    logic        h_bl  [8];
    logic [19:0] h_scr [8];

    // Model state and expected outputs
    logic [N-1:0] m_acc = '0;
    logic [N-1:0] m_col = '0;
    logic [7:0]   m_frame = 8'd0;
    logic         m_pvs = 1'b1;
    logic         ex_hs, ex_vs, ex_stb;
    logic [19:0]  ex_scr;
    logic [23:0]  ex_vp;

    initial begin
        for (int i = 0; i < 8; i++) begin
            h_rst[i] = 1'b1; h_hs[i] = 1'b1; h_vs[i] = 1'b1; h_bl[i] = 1'b1; h_scr[i] = '0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Spec-level model of one clock edge, using the inputs present at that edge.
    task automatic model_step();
        int s;
        logic wr, t_hs, t_vs, t_bl;
        logic [19:0] t_scr;
        logic [N-1:0] eff;
        s = edge_n % 8;
        h_rst[s] = i_rst; h_hs[s] = i_hsync; h_vs[s] = i_vsync; h_bl[s] = i_blank; h_scr[s] = i_screen;
        if (i_rst) begin
            ex_hs = 1'b1; ex_vs = 1'b1; ex_scr = '0; ex_vp = '0; ex_stb = 1'b0;
            m_acc = '0; m_col = '0; m_frame = '0; m_pvs = 1'b1;
        end else begin
            // A reset anywhere in the last D edges wiped the sample that would emerge now.
            wr = 1'b0;
            for (int j = 1; j <= D; j++) if (h_rst[(edge_n - j) % 8]) wr = 1'b1;
            if (wr) begin
                t_hs = 1'b1; t_vs = 1'b1; t_bl = 1'b1; t_scr = '0;
            end else begin
                t_hs = h_hs[(edge_n - D) % 8]; t_vs = h_vs[(edge_n - D) % 8];
                t_bl = h_bl[(edge_n - D) % 8]; t_scr = h_scr[(edge_n - D) % 8];
            end
            eff = i_req & i_layer_en;
            ex_vp = BG;
            for (int k = N - 1; k >= 0; k--) begin
                if (eff[k]) begin
                    ex_vp = i_vport[k*24 +: 24];
                    break;
                end
            end
            if (t_bl) ex_vp = 24'h000000;
            if (!t_bl && $countones(eff) >= 2) m_acc = m_acc | eff;
            ex_stb = m_pvs && !t_vs;
            if (ex_stb) begin
                m_col = m_acc;
                m_acc = '0;
                m_frame = m_frame + 8'd1;
            end
            m_pvs = t_vs;
            ex_hs = t_hs; ex_vs = t_vs; ex_scr = t_scr;
        end
        edge_n++;
    endtask

    // Advance one cycle, then compare every output with the model.
    task automatic tick();
        @(posedge i_clk);
        #1;
        model_step();
        chk("hsync",   32'(o_hsync),       32'(ex_hs));
        chk("vsync",   32'(o_vsync),       32'(ex_vs));
        chk("screen",  32'(o_screen),      32'(ex_scr));
        chk("vport",   32'(o_vport),       32'(ex_vp));
        chk("collide", 32'(o_collide),     32'(m_col));
        chk("stb",     32'(o_collide_stb), 32'(ex_stb));
        chk("frame",   32'(o_frame),       32'(m_frame));
        if (o_collide_stb) strobes++;
    endtask

    task automatic setv(input int k, input logic [23:0] v);
        i_vport[k*24 +: 24] = v;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    // Wait (bounded) for a strobe and pin its payload.
    task automatic wait_stb(input string nm, input logic [N-1:0] ecol, input logic [7:0] efr);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            if (o_collide_stb) begin
                found = 1'b1;
                chk({nm, "_collide"}, 32'(o_collide), 32'(ecol));
                chk({nm, "_frame"},   32'(o_frame),   32'(efr));
            end
        end
        chk({nm, "_seen"}, 32'(found), 32'd1);
    endtask

    int s0;

    initial begin
        i_rst = 1'b1; i_hsync = 1'b1; i_vsync = 1'b1; i_blank = 1'b1; i_screen = '0;
        i_vport = '0; i_req = '0; i_layer_en = 4'hF;

        // Reset with random inputs
        repeat (3) begin
            i_hsync = 1'($urandom); i_vsync = 1'($urandom); i_blank = 1'($urandom);
            i_screen = 20'($urandom); i_vport = {$urandom, $urandom, $urandom};
            i_req = 4'($urandom); i_layer_en = 4'($urandom);
            tick();
        end
        chk("rst_vport",   32'(o_vport),       32'h0);
        chk("rst_hsync",   32'(o_hsync),       32'h1);
        chk("rst_vsync",   32'(o_vsync),       32'h1);
        chk("rst_frame",   32'(o_frame),       32'h0);
        chk("rst_collide", 32'(o_collide),     32'h0);
        chk("rst_stb",     32'(o_collide_stb), 32'h0);

        // Reset values persist while the delay line refills
        i_rst = 1'b0; i_hsync = 1'b0; i_vsync = 1'b1; i_blank = 1'b0;
        i_req = 4'hF; i_layer_en = 4'hF;
        repeat (D) begin
            tick();
            chk("post_rst_vport", 32'(o_vport), 32'h0);
            chk("post_rst_hsync", 32'(o_hsync), 32'h1);
        end
        i_hsync = 1'b1; i_req = '0; i_vport = '0; i_screen = '0;
        repeat (4) tick();

        // Alignment
        i_hsync = 1'b0; i_screen = 20'h0A005;
        tick();
        i_hsync = 1'b1; i_screen = '0;
        tick();
        i_req = 4'b0001; setv(0, 24'h123456);
        tick();
        chk("align_hsync",  32'(o_hsync),  32'h0);
        chk("align_screen", 32'(o_screen), 32'h0A005);
        chk("align_vport",  32'(o_vport),  32'h123456);
        i_req = '0;

        // Priority and enable
        setv(2, 24'hFF0000); setv(0, 24'h0000FF); i_req = 4'b0101;
        tick();
        chk("prio_hi", 32'(o_vport), 32'hFF0000);
        i_layer_en = 4'b1011;
        tick();
        chk("prio_en", 32'(o_vport), 32'h0000FF);
        i_layer_en = 4'hF; i_req = '0;
        tick();
        chk("prio_bg", 32'(o_vport), 32'(BG));
        i_blank = 1'b1; i_req = 4'b0101;
        repeat (D + 1) tick();
        chk("prio_blank", 32'(o_vport), 32'h0);
        i_blank = 1'b0; i_req = '0;

        // Collision frame
        do_reset();
        repeat (3) tick();
        i_req = 4'b0011; repeat (5) tick();
        i_req = 4'b1000; setv(3, 24'h00FF00); tick();
        i_req = '0; i_blank = 1'b1; repeat (D + 1) tick();
        i_req = 4'b0110; repeat (2) tick();
        i_req = '0; i_vsync = 1'b0;
        wait_stb("coll1", 4'b0011, 8'd1);
        i_vsync = 1'b1; i_blank = 1'b0;
        repeat (3) tick();
        i_req = 4'b0001; repeat (3) tick();
        i_req = '0; i_vsync = 1'b0;
        wait_stb("coll2", 4'b0000, 8'd2);
        i_vsync = 1'b1;

        // Frame counter wrap
        do_reset();
        tick();
        s0 = strobes;
        repeat (256) begin
            i_vsync = 1'b0; tick();
            i_vsync = 1'b1; tick();
        end
        repeat (D + 2) tick();
        chk("wrap_strobes", 32'(strobes - s0), 32'd256);
        chk("wrap_frame",   32'(o_frame),      32'd0);

        // Held vsync
        s0 = strobes;
        i_vsync = 1'b0; repeat (100) tick();
        i_vsync = 1'b1; repeat (D + 2) tick();
        chk("held_strobes", 32'(strobes - s0), 32'd1);

        // Mid-frame reset discards overlap
        i_blank = 1'b0; i_req = 4'b1010;
        repeat (4) tick();
        do_reset();
        i_req = '0; repeat (4) tick();
        i_req = 4'b0100; repeat (2) tick();
        i_req = '0; i_vsync = 1'b0;
        wait_stb("midrst", 4'b0000, 8'd1);
        i_vsync = 1'b1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
